rom_burst_reader: RTL and testbench
===================================

Name: rom_burst_reader

Overview:
- Initiator for the OpenROM single-port read interface (`cs`/`addr` → `dout`). Accepts a burst request (start address, word count) on a valid/ready port.
- Issues consecutive ROM reads and streams the returned words out on a valid/ready stream with a `last` flag.
- Sits between the testchip's management/logic-analyzer control path and a ROM macro such as the 8x1024 ROM. Absorbs the ROM's fixed read latency and downstream backpressure with a small buffer.

Parameters:
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 10, ROM address width; ROM_DEPTH = 1<<ADDR_WIDTH.
- FIFO_DEPTH, 4, output buffer entries; power of two, >=4.

Ports:
- clk  in  1  single clock; also drives the ROM clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  first word address.
- req_len  in  ADDR_WIDTH  word count minus 1 (0 → 1 word, all-ones → ROM_DEPTH words).
- rom_cs  out  1  registered chip select to ROM.
- rom_addr  out  ADDR_WIDTH  registered address to ROM.
- rom_dout  in  DATA_WIDTH  ROM read data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream sink ready.
- out_data  out  DATA_WIDTH  ROM word.
- out_last  out  1  final word of burst.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: rom_cs=0, rom_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, req_ready=1 (after reset), state=IDLE.
- Reset flushes the FIFO and discards in-flight reads; reset mid-burst gives no further beats.
- States:
  - IDLE: req_ready=1. On req_valid, latch cur_addr=req_addr and remaining=req_len, then go to ISSUE.
  - ISSUE: each cycle, issue one read iff credit is available (see below). Issue = register rom_cs=1, rom_addr=cur_addr; cur_addr += 1 mod ROM_DEPTH (wraps 1023 → 0). When a read is issued with remaining==0, go to DRAIN; otherwise remaining -= 1.
  - DRAIN: rom_cs=0. Return to IDLE on the cycle the beat with out_last is accepted.
- rom_cs deasserts in any cycle with no issue; rom_addr holds its last value.
- Read pipeline:
  - rom_cs/rom_addr are registered at edge k; the ROM samples them at edge k+1.
  - The controller captures rom_dout into the FIFO at edge k+2. A 2-stage valid shift register tracks this.
- Credit rule: issue iff fifo_count + inflight_count < FIFO_DEPTH, using registered values only (a same-cycle pop is not credited). The FIFO never overflows.
- Latency: request accepted at edge E0 → rom_cs high after E1 → out_valid high after E3. Throughput is 1 word/cycle while out_ready=1.
- Stream rule: out_data/out_last are stable while out_valid=1 and out_ready=0. out_last is stored per entry and set on the word issued with remaining==0.
- The next request cannot be accepted until the final beat has been accepted, so back-to-back bursts have a 1-cycle IDLE gap.
- FIFO simultaneous push+pop when full is allowed; the credit rule guarantees a push never targets a full FIFO without a pop.

Optional Feature:
- Macro ROM_BURST_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` [DATA_WIDTH-1:0]: XOR of all words accepted on the stream in the current burst, including the last.
  - Cleared to 0 on request acceptance and on reset.
  - Updated on each accepted beat; holds its final value after the out_last beat until the next request is accepted.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package rom_burst_pkg: state enum (IDLE, ISSUE, DRAIN) and default width constants.
- Sub-module rom_burst_fifo: synchronous FIFO of {last, data}, FIFO_DEPTH entries, with count, full and empty outputs. It owns the flush on reset.

Test Plan:
- Single word: req_addr=0x005, req_len=0, out_ready=1 → one rom_cs pulse with addr 0x005; out_valid after 3 cycles with data=mem[5], out_last=1; busy falls next cycle.
- Full-rate burst: addr=0x000, len=3, out_ready=1 → rom_cs high 4 consecutive cycles (addr 0,1,2,3); 4 consecutive beats; out_last only on the 4th.
- Wrap: addr=0x3FE, len=3 → rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; data matches in order.
- Backpressure: len=15, out_ready low for 8 cycles after the 2nd beat → rom_cs stops once FIFO_DEPTH is reached; no loss or duplication; all 16 beats in order; out_data stable while stalled.
- Reset mid-burst: assert reset for 1 cycle during ISSUE of a len=15 burst → next cycle rom_cs=0, out_valid=0, req_ready=1; a following burst at 0x010 returns correct data.
- Checksum (ROM_BURST_CHECKSUM_EN): burst of words 0x12, 0x34, 0x0F → checksum=0x29 after the last beat, held until the next request.

Source files
------------

// File: rtl/rom_burst_pkg.sv
// Shared types and default widths for the ROM burst reader.
package rom_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/rom_burst_fifo.sv
// Output buffer for the burst reader: synchronous FIFO of {last, data}.
// Reset flushes both the pointers and the storage so the head reads zero.
module rom_burst_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;

    // Storage, pointers and occupancy; pop on empty is prevented by the reader.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = (count_r == (PW+1)'(DEPTH));
    assign empty    = (count_r == {(PW+1){1'b0}});

endmodule

// File: rtl/rom_burst_reader.sv
// Burst initiator for a single-port ROM: issues sequential reads and streams words out.
// Optional macro ROM_BURST_CHECKSUM_EN adds a per-burst XOR checksum output.
module rom_burst_reader
    import rom_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH-1:0] req_len,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
`ifdef ROM_BURST_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] cur_addr_r;
    logic [ADDR_WIDTH-1:0] remaining_r;
    logic                  rom_cs_r;
    logic [ADDR_WIDTH-1:0] rom_addr_r;
    logic [1:0]            pipe_r;
    logic [1:0]            last_pipe_r;
    logic                  busy_r;
    logic                  req_ready_r;

    logic                  issue_s;
    logic                  accept_s;
    logic                  credit_s;
    logic                  pop_s;
    logic                  final_s;
    logic [1:0]            inflight_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [DATA_WIDTH:0]   head_s;

    // Credit counts only registered occupancy, so a same-cycle pop never frees a slot early.
    assign inflight_s = {1'b0, pipe_r[0]} + {1'b0, pipe_r[1]};
    assign credit_s   = !fifo_full_s &&
                        (({1'b0, fifo_count_s} + {{(CW-1){1'b0}}, inflight_s}) < (CW+1)'(FIFO_DEPTH));
    assign final_s    = (remaining_r == {ADDR_WIDTH{1'b0}});
    assign out_valid  = !fifo_empty_s;
    assign pop_s      = out_valid && out_ready;

    // Next-state and issue decision.
    always_comb begin
        state_s  = state_r;
        issue_s  = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = req_valid;
                if (req_valid) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                issue_s = credit_s;
                if (credit_s && final_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && head_s[DATA_WIDTH]) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, address/length counters, ROM strobes and read-latency pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            cur_addr_r  <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {ADDR_WIDTH{1'b0}};
            rom_cs_r    <= 1'b0;
            rom_addr_r  <= {ADDR_WIDTH{1'b0}};
            pipe_r      <= 2'b00;
            last_pipe_r <= 2'b00;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            req_ready_r <= (state_s == IDLE);
            if (accept_s) begin
                cur_addr_r  <= req_addr;
                remaining_r <= req_len;
            end else if (issue_s) begin
                cur_addr_r  <= cur_addr_r + ADDR_WIDTH'(1);
                remaining_r <= remaining_r - ADDR_WIDTH'(1);
            end
            rom_cs_r <= issue_s;
            if (issue_s) begin
                rom_addr_r <= cur_addr_r;
            end
            pipe_r      <= {pipe_r[0], issue_s};
            last_pipe_r <= {last_pipe_r[0], issue_s && final_s};
        end
    end

    rom_burst_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_r[1]),
        .push_data ({last_pipe_r[1], rom_dout}),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign out_data  = head_s[DATA_WIDTH-1:0];
    assign out_last  = head_s[DATA_WIDTH];
    assign rom_cs    = rom_cs_r;
    assign rom_addr  = rom_addr_r;
    assign busy      = busy_r;
    assign req_ready = req_ready_r;

`ifdef ROM_BURST_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_r;

    // Running XOR of accepted beats, cleared when a new burst is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (pop_s) begin
            checksum_r <= checksum_r ^ out_data;
        end
    end

    assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: random ROM contents, directed and random bursts checked against an address-arithmetic model.
module tb_rom_burst_reader;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef ROM_BURST_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] rom_mem [1024];
    int vectors = 0;
    int miscompares = 0;

    rom_burst_reader dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef ROM_BURST_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ROM macro: samples cs/addr on the edge and presents data after it.
    always_ff @(posedge clk) begin
        if (rom_cs) rom_dout <= rom_mem[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One burst: expected word i is rom_mem[(addr+i) mod 1024], last on i==len.
    task automatic do_burst(input int addr, input int len, input int stall_at, input int stall_len);
        int t, issued, beats, first_cs, last_cs, first_v, stall_left;
        logic prev_stall;
        logic [DW-1:0] prev_data;
        logic prev_last;
        logic [DW-1:0] exp_sum;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr[AW-1:0];
        req_len   = len[AW-1:0];
        tick();
        req_valid = 1'b0;
        req_addr  = AW'($urandom_range(0, 1023));
        req_len   = AW'($urandom_range(0, 1023));
        check("busy_after_accept", busy, 1);
        check("req_ready_busy", req_ready, 0);
`ifdef ROM_BURST_CHECKSUM_EN
        check("checksum_cleared", checksum, 0);
`endif
        issued = 0; beats = 0; first_cs = -1; last_cs = -1; first_v = -1;
        stall_left = stall_len; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        exp_sum = '0; t = 0;
        while (beats <= len && t < 400) begin
            if (beats == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                if (stall_len >= 8 && stall_left == 0) check("stall_cs_off", rom_cs, 0);
            end else begin
                out_ready = 1'b1;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (rom_cs) begin
                check("rom_addr", rom_addr, (addr + issued) % 1024);
                if (first_cs < 0) first_cs = t;
                last_cs = t;
                issued++;
                check("outstanding_bound", (issued - beats) <= DEPTH, 1);
            end
            if (out_valid && first_v < 0) first_v = t;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                check("beat_data", out_data, rom_mem[(addr + beats) % 1024]);
                check("beat_last", out_last, (beats == len));
                exp_sum = exp_sum ^ rom_mem[(addr + beats) % 1024];
                beats++;
            end
            tick();
            t++;
        end
        out_ready = 1'b1;
        check("beats_total", beats, len + 1);
        check("issued_total", issued, len + 1);
        check("busy_end", busy, 0);
        check("req_ready_end", req_ready, 1);
        check("cs_end", rom_cs, 0);
        check("first_cs_cycle", first_cs, 1);
        check("first_valid_cycle", first_v, 3);
        if (stall_len == 0) begin
            check("full_rate_issue", last_cs - first_cs, len);
            check("burst_cycles", t, len + 4);
        end
`ifdef ROM_BURST_CHECKSUM_EN
        check("checksum_final", checksum, exp_sum);
        tick();
        check("checksum_hold", checksum, exp_sum);
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = DW'($urandom);
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_rom_cs", rom_cs, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);

        do_burst(32'h005, 0, -1, 0);     // single word
        tick();
        do_burst(32'h000, 3, -1, 0);     // full-rate burst
        do_burst(32'h3FE, 3, -1, 0);     // wrap 3FE,3FF,000,001
        do_burst(32'h123, 15, 2, 8);     // backpressure after 2nd beat

        // Reset in the middle of issuing a 16-word burst.
        req_valid = 1'b1; req_addr = 10'h200; req_len = 10'd15;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("pre_reset_cs", rom_cs, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_rom_cs", rom_cs, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_beat", out_valid, 0);
        end
        do_burst(32'h010, 5, -1, 0);

        for (int n = 0; n < 6; n++) begin
            int a, l;
            a = $urandom_range(0, 1023);
            l = $urandom_range(0, 12);
            do_burst(a, l, $urandom_range(0, l), $urandom_range(0, 6));
        end

`ifdef ROM_BURST_CHECKSUM_EN
        rom_mem[10'h100] = 8'h12;
        rom_mem[10'h101] = 8'h34;
        rom_mem[10'h102] = 8'h0F;
        do_burst(32'h100, 2, -1, 0);
        check("checksum_0x29", checksum, 32'h29);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
